// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU memory stage, the DMA/IO requester and the data memory.
// The arbiter takes the slave view; the surrounding datapath/bench takes the master view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [2:0]        cpu_width;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  // DMA handshake: a request transfers in a cycle where dma_valid & dma_ready.
  // While dma_valid & !dma_ready the fields are held stable; valid may drop without a transfer.
  logic              dma_valid;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [2:0]        dma_width;
  logic              dma_ready;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [2:0]        mem_width;
  logic [DATA_W-1:0] mem_rdata;

  logic [1:0]        arb_state;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_width,
    input  dma_valid, dma_we, dma_addr, dma_wdata, dma_width,
    input  mem_rdata,
    output cpu_rdata, cpu_stall,
    output dma_ready, dma_rvalid, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_width,
    output arb_state
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_width,
    output dma_valid, dma_we, dma_addr, dma_wdata, dma_width,
    output mem_rdata,
    input  cpu_rdata, cpu_stall,
    input  dma_ready, dma_rvalid, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_width,
    input  arb_state
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU memory stage has fixed priority over DMA, with DMA
// starvation bounded by MAX_CPU_BURST consecutive CPU grants. One read in flight.
module dmem_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int RD_LAT        = 2,
  parameter int MAX_CPU_BURST = 4
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  if (RD_LAT < 1 || RD_LAT > 4 || MAX_CPU_BURST < 1 || MAX_CPU_BURST > 15) begin : g_bad_param
    $error("dmem_arbiter: RD_LAT must be 1..4 and MAX_CPU_BURST 1..15");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_CPU = 2'd1,
    RD_DMA = 2'd2
  } state_t;

  localparam logic [3:0] MAX_C  = 4'(MAX_CPU_BURST);
  localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [3:0]        starve_q, starve_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

  logic rd_done, cpu_rd_done, dma_rd_done;
  logic can_issue, cpu_live, sel_cpu, sel_dma, issue_we;

  always_comb begin
    rd_done     = (state_q != IDLE) && (cnt_q == 3'd0);
    cpu_rd_done = (state_q == RD_CPU) && (cnt_q == 3'd0);
    dma_rd_done = (state_q == RD_DMA) && (cnt_q == 3'd0);
    can_issue   = (state_q == IDLE) || rd_done;
    // A CPU read is finished in its completion cycle even though cpu_req is still high.
    cpu_live    = bus.cpu_req && !cpu_rd_done;
    sel_dma     = can_issue && bus.dma_valid && (!cpu_live || (starve_q == MAX_C));
    sel_cpu     = can_issue && cpu_live && !sel_dma;
    issue_we    = sel_dma ? bus.dma_we : bus.cpu_we;

    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q != IDLE) begin
      if (rd_done) state_d = IDLE;
      else         cnt_d   = cnt_q - 3'd1;
    end
    if ((sel_cpu || sel_dma) && !issue_we) begin
      state_d = sel_dma ? RD_DMA : RD_CPU;
      cnt_d   = LAT_M1;
    end

    starve_d = starve_q;
    if (!bus.dma_valid || sel_dma)        starve_d = 4'd0;
    else if (sel_cpu && starve_q < MAX_C) starve_d = starve_q + 4'd1;

    dma_rdata_d = dma_rd_done ? bus.mem_rdata : dma_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      starve_q    <= 4'd0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // Outputs are forced quiet during reset so an in-flight read cannot leak a completion.
  always_comb begin
    bus.mem_en     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.mem_width  = 3'd0;
    bus.dma_ready  = 1'b0;
    bus.dma_rvalid = 1'b0;
    bus.dma_rdata  = '0;
    bus.cpu_stall  = 1'b0;
    bus.cpu_rdata  = '0;
    bus.arb_state  = state_q;
    if (rst) begin
      if (sel_dma) begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.dma_we;
        bus.mem_addr  = bus.dma_addr;
        bus.mem_wdata = bus.dma_wdata;
        bus.mem_width = bus.dma_width;
        bus.dma_ready = 1'b1;
      end else if (sel_cpu) begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.cpu_we;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        bus.mem_width = bus.cpu_width;
      end
      bus.dma_rvalid = dma_rd_done;
      bus.dma_rdata  = dma_rdata_d;
      bus.cpu_stall  = bus.cpu_req && !((sel_cpu && bus.cpu_we) || cpu_rd_done);
      if (cpu_rd_done) bus.cpu_rdata = bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed cycle table for the corner cases, then randomized
// traffic checked against a cycle-numbered reference model and a DMA read scoreboard.
module tb_dmem_arbiter;
  localparam int ADDR_W        = 32;
  localparam int DATA_W        = 32;
  localparam int RD_LAT        = 2;
  localparam int MAX_CPU_BURST = 4;
  localparam logic [2:0] CPU_W = 3'd2;
  localparam logic [2:0] DMA_W = 3'd5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_CPU_BURST(MAX_CPU_BURST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  typedef struct {
    logic        rst;
    logic        creq, cwe;
    logic [31:0] ca, cwd;
    logic        dv, dwe;
    logic [31:0] da, dwd, mrd;
    logic        en, we;
    logic [31:0] maddr, mwd;
    logic        stall, rdy, rv;
    logic [31:0] drd;
    logic        chk;
    logic [31:0] crd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(
    input logic r, input logic creq, input logic cwe, input logic [31:0] ca, input logic [31:0] cwd,
    input logic dv, input logic dwe, input logic [31:0] da, input logic [31:0] dwd, input logic [31:0] mrd,
    input logic en, input logic we, input logic [31:0] maddr, input logic [31:0] mwd,
    input logic stall, input logic rdy, input logic rv, input logic [31:0] drd,
    input logic chk, input logic [31:0] crd);
    vec_t v;
    v.rst = r; v.creq = creq; v.cwe = cwe; v.ca = ca; v.cwd = cwd;
    v.dv = dv; v.dwe = dwe; v.da = da; v.dwd = dwd; v.mrd = mrd;
    v.en = en; v.we = we; v.maddr = maddr; v.mwd = mwd;
    v.stall = stall; v.rdy = rdy; v.rv = rv; v.drd = drd; v.chk = chk; v.crd = crd;
    vecs.push_back(v);
  endfunction

  // Contention row: CPU and DMA both present writes; is_dma says who must win.
  function automatic void add_wr(input logic dv, input logic is_dma);
    add(1, 1, 1, 32'h300, 32'hA, dv, 1, 32'h400, 32'hB, 0,
        1, 1, is_dma ? 32'h400 : 32'h300, is_dma ? 32'hB : 32'hA,
        is_dma, is_dma, 0, 32'hCAFEF00D, 0, 0);
  endfunction

  task automatic build_table();
    // reset, quiet and with requests present
    add(0, 0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0, 1,0);
    add(0, 1,1,32'h50,32'h1, 1,0,32'h60,0,32'h77, 0,0,0,0, 0,0,0,0, 1,0);
    // store
    add(1, 1,1,32'h100,32'hDEADBEEF, 0,0,0,0,0, 1,1,32'h100,32'hDEADBEEF, 0,0,0,0, 0,0);
    add(1, 0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0);
    // CPU load, RD_LAT=2
    add(1, 1,0,32'h104,32'h55, 0,0,0,0,32'h1111, 1,0,32'h104,32'h55, 1,0,0,0, 0,0);
    add(1, 1,0,32'h104,32'h55, 0,0,0,0,32'h2222, 0,0,0,0, 1,0,0,0, 0,0);
    add(1, 1,0,32'h104,32'h55, 0,0,0,0,32'h12345678, 0,0,0,0, 0,0,0,0, 1,32'h12345678);
    add(1, 0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0);
    // DMA read alone
    add(1, 0,0,0,0, 1,0,32'h200,0,32'h3333, 1,0,32'h200,0, 0,1,0,0, 0,0);
    add(1, 0,0,0,0, 0,0,0,0,32'hBAD, 0,0,0,0, 0,0,0,0, 0,0);
    add(1, 0,0,0,0, 0,0,0,0,32'hCAFEF00D, 0,0,0,0, 0,0,1,32'hCAFEF00D, 0,0);
    add(1, 0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,32'hCAFEF00D, 0,0);
    // contention: CPU x4, DMA x1, twice
    for (int k = 0; k < 10; k++) add_wr(1, (k % 5) == 4);
    // counter clear: 3 CPU, valid drops, then 4 CPU before DMA
    for (int k = 0; k < 3; k++) add_wr(1, 0);
    add_wr(0, 0);
    for (int k = 0; k < 4; k++) add_wr(1, 0);
    add_wr(1, 1);
    // reset during DMA read
    add(1, 0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,32'hCAFEF00D, 0,0);
    add(1, 0,0,0,0, 1,0,32'h500,0,0, 1,0,32'h500,0, 0,1,0,32'hCAFEF00D, 0,0);
    add(0, 0,0,0,0, 0,0,0,0,32'hFFFF, 0,0,0,0, 0,0,0,0, 1,0);
    add(1, 1,1,32'h600,32'h66, 0,0,0,0,32'hABCDABCD, 1,1,32'h600,32'h66, 0,0,0,0, 0,0);
    add(1, 0,0,0,0, 0,0,0,0,32'hABCDABCD, 0,0,0,0, 0,0,0,0, 0,0);
  endtask

  task automatic run_table();
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      cyc++;
      rst           = vecs[i].rst;
      bus.cpu_req   = vecs[i].creq;  bus.cpu_we   = vecs[i].cwe;
      bus.cpu_addr  = vecs[i].ca;    bus.cpu_wdata = vecs[i].cwd;  bus.cpu_width = CPU_W;
      bus.dma_valid = vecs[i].dv;    bus.dma_we   = vecs[i].dwe;
      bus.dma_addr  = vecs[i].da;    bus.dma_wdata = vecs[i].dwd;  bus.dma_width = DMA_W;
      bus.mem_rdata = vecs[i].mrd;
      @(negedge clk);
      check($sformatf("v%0d mem_en", i),     bus.mem_en,     vecs[i].en);
      check($sformatf("v%0d mem_we", i),     bus.mem_we,     vecs[i].we);
      check($sformatf("v%0d mem_addr", i),   bus.mem_addr,   vecs[i].maddr);
      check($sformatf("v%0d mem_wdata", i),  bus.mem_wdata,  vecs[i].mwd);
      check($sformatf("v%0d mem_width", i),  bus.mem_width,
            vecs[i].en ? (vecs[i].rdy ? DMA_W : CPU_W) : 3'd0);
      check($sformatf("v%0d cpu_stall", i),  bus.cpu_stall,  vecs[i].stall);
      check($sformatf("v%0d dma_ready", i),  bus.dma_ready,  vecs[i].rdy);
      check($sformatf("v%0d dma_rvalid", i), bus.dma_rvalid, vecs[i].rv);
      check($sformatf("v%0d dma_rdata", i),  bus.dma_rdata,  vecs[i].drd);
      if (vecs[i].chk) check($sformatf("v%0d cpu_rdata", i), bus.cpu_rdata, vecs[i].crd);
    end
  endtask

  // Reference model: a read issued in cycle c completes in cycle c+RD_LAT; the port is
  // free when nothing is outstanding or the outstanding read completes this cycle.
  logic [DATA_W-1:0] exp_q[$];

  task automatic run_random(input int n);
    bit          m_busy = 0, m_own_dma = 0;
    int          m_done_cyc = 0, m_waits = 0;
    logic [31:0] m_cpu_exp = 0, m_last_drd = 0;
    bit          cpu_hold = 0, dma_hold = 0;
    int          rd_issue_cyc = -100;
    logic [31:0] rd_addr = 0;
    logic        r, creq, cwe, dv, dwe;
    logic [31:0] ca, cwd, da, dwd;
    logic [2:0]  cw, dw;
    bit          done, cpu_done_rd, dma_done, free, cpu_live, pick_dma, pick_cpu, pick, pwe;
    logic [31:0] e_addr, e_wd, e_drd;
    logic [2:0]  e_w;
    bit          e_stall;
    creq = 0; cwe = 0; ca = 0; cwd = 0; cw = 0;
    dv = 0; dwe = 0; da = 0; dwd = 0; dw = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cyc++;
      r = ($urandom_range(0, 59) != 0);
      if (!cpu_hold) begin
        creq = ($urandom_range(0, 2) != 0); cwe = 1'($urandom_range(0, 1));
        ca = $urandom; cwd = $urandom; cw = 3'($urandom_range(0, 7));
      end
      if (!dma_hold) begin
        dv = 1'($urandom_range(0, 1)); dwe = 1'($urandom_range(0, 1));
        da = $urandom; dwd = $urandom; dw = 3'($urandom_range(0, 7));
      end else if ($urandom_range(0, 7) == 0) begin
        dv = 0;
      end
      rst = r;
      bus.cpu_req = creq; bus.cpu_we = cwe; bus.cpu_addr = ca; bus.cpu_wdata = cwd; bus.cpu_width = cw;
      bus.dma_valid = dv; bus.dma_we = dwe; bus.dma_addr = da; bus.dma_wdata = dwd; bus.dma_width = dw;
      bus.mem_rdata = (cyc == rd_issue_cyc + RD_LAT) ? mem_fn(rd_addr) : $urandom;

      if (r) begin
        done        = m_busy && (cyc == m_done_cyc);
        cpu_done_rd = done && !m_own_dma;
        dma_done    = done && m_own_dma;
        free        = !m_busy || done;
        cpu_live    = creq && !cpu_done_rd;
        pick_dma    = free && dv && (!cpu_live || m_waits == MAX_CPU_BURST);
        pick_cpu    = free && cpu_live && !pick_dma;
        pick        = pick_dma || pick_cpu;
        pwe         = pick_dma ? dwe : (pick_cpu ? cwe : 1'b0);
        e_addr      = pick_dma ? da  : (pick_cpu ? ca  : 32'h0);
        e_wd        = pick_dma ? dwd : (pick_cpu ? cwd : 32'h0);
        e_w         = pick_dma ? dw  : (pick_cpu ? cw  : 3'd0);
        e_stall     = creq && !((pick_cpu && cwe) || cpu_done_rd);
        e_drd       = m_last_drd;
        if (dma_done) begin
          if (exp_q.size() > 0) e_drd = exp_q.pop_front();
          else check("r scoreboard empty", 1, 0);
        end
      end else begin
        done = 0; cpu_done_rd = 0; dma_done = 0; pick = 0; pick_dma = 0; pick_cpu = 0;
        pwe = 0; e_addr = 0; e_wd = 0; e_w = 0; e_stall = 0; e_drd = 0;
      end

      @(negedge clk);
      check($sformatf("r%0d mem_en", i),     bus.mem_en,     pick);
      check($sformatf("r%0d mem_we", i),     bus.mem_we,     pwe);
      check($sformatf("r%0d mem_addr", i),   bus.mem_addr,   e_addr);
      check($sformatf("r%0d mem_wdata", i),  bus.mem_wdata,  e_wd);
      check($sformatf("r%0d mem_width", i),  bus.mem_width,  e_w);
      check($sformatf("r%0d cpu_stall", i),  bus.cpu_stall,  e_stall);
      check($sformatf("r%0d dma_ready", i),  bus.dma_ready,  pick_dma);
      check($sformatf("r%0d dma_rvalid", i), bus.dma_rvalid, dma_done);
      check($sformatf("r%0d dma_rdata", i),  bus.dma_rdata,  e_drd);
      if (cpu_done_rd || !r)
        check($sformatf("r%0d cpu_rdata", i), bus.cpu_rdata, r ? m_cpu_exp : 32'h0);

      // memory responder watches the issued reads
      if (bus.mem_en && !bus.mem_we) begin
        rd_issue_cyc = cyc;
        rd_addr      = bus.mem_addr;
      end

      if (r) begin
        if (done) m_busy = 0;
        if (pick && !pwe) begin
          m_busy = 1; m_own_dma = pick_dma; m_done_cyc = cyc + RD_LAT;
          if (pick_dma) exp_q.push_back(mem_fn(da));
          else          m_cpu_exp = mem_fn(ca);
        end
        m_last_drd = e_drd;
        if (!dv || pick_dma) m_waits = 0;
        else if (pick_cpu && m_waits < MAX_CPU_BURST) m_waits++;
        cpu_hold = e_stall;
        dma_hold = dv && !pick_dma;
      end else begin
        m_busy = 0; m_waits = 0; m_last_drd = 0; exp_q.delete();
        cpu_hold = 0; dma_hold = 0;
      end
    end
  endtask

  initial begin
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0; bus.cpu_width = 0;
    bus.dma_valid = 0; bus.dma_we = 0; bus.dma_addr = 0; bus.dma_wdata = 0; bus.dma_width = 0;
    bus.mem_rdata = 0;
    build_table();
    run_table();
    run_random(400);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
